// File: rtl/l3_uart_tx.sv
// l3_uart_tx: drains 4x18-bit pooled entries from the layer-3 RAM and
// streams them as 8N1 UART bytes (ch0 first, LS byte first, 24-bit sext).
// Ports: clk, rst_n (async low), rd (entry available), din[3:0][17:0],
//   addr_rd_inc (read-advance pulse), tx_done (frame-end pulse), tx, busy.
// Option: L3_UART_TX_HDR_EN adds a 0xA5 header and a sum-8 checksum.
module l3_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int NUM_ENTRIES  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rd,
  input  logic [3:0][17:0] din,
  output logic            addr_rd_inc,
  output logic            tx_done,
  output logic            tx,
  output logic            busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);
  localparam logic [4:0] ELAST = 5'(NUM_ENTRIES - 1);

  typedef enum logic [2:0] {
    IDLE, WAIT, CAPT, SEND, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [95:0]   shreg_q, shreg_d;
  logic [7:0]    byte_q, byte_d;
  logic [3:0]    byte_idx_q, byte_idx_d;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [4:0]    ent_q, ent_d;
  logic          tx_q, tx_d;
  logic          inc_q, inc_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          nxt;
`ifdef L3_UART_TX_HDR_EN
  logic          hdr_q, hdr_d;
  logic          ck_q, ck_d;
  logic [7:0]    csum_q, csum_d;
`endif

  logic [95:0] cap_w;

  assign cap_w = {
    {{6{din[3][17]}}, din[3]},
    {{6{din[2][17]}}, din[2]},
    {{6{din[1][17]}}, din[1]},
    {{6{din[0][17]}}, din[0]}
  };

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    byte_d     = byte_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    tmr_d      = tmr_q;
    ent_d      = ent_q;
    nxt        = 1'b0;
`ifdef L3_UART_TX_HDR_EN
    hdr_d      = hdr_q;
    ck_d       = ck_q;
    csum_d     = csum_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (rd) state_d = WAIT;
      end
      WAIT: begin
        state_d = CAPT;
      end
      CAPT: begin
        tmr_d      = '0;
        bit_idx_d  = '0;
        byte_idx_d = '0;
        state_d    = SEND;
`ifdef L3_UART_TX_HDR_EN
        if (ent_q == 5'd0) begin
          byte_d  = 8'hA5;
          shreg_d = cap_w;
          hdr_d   = 1'b1;
        end else begin
          byte_d  = cap_w[7:0];
          shreg_d = {8'h00, cap_w[95:8]};
          csum_d  = csum_q + cap_w[7:0];
        end
`else
        byte_d  = cap_w[7:0];
        shreg_d = {8'h00, cap_w[95:8]};
`endif
      end
      SEND: begin
        if (tmr_q != TMAX) begin
          tmr_d = tmr_q + 1'b1;
        end else begin
          tmr_d = '0;
          if (bit_idx_q != 4'd9) begin
            bit_idx_d = bit_idx_q + 4'd1;
          end else begin
            bit_idx_d = '0;
`ifdef L3_UART_TX_HDR_EN
            if (hdr_q) begin
              hdr_d = 1'b0;
              nxt   = 1'b1;
            end else if (ck_q) begin
              ck_d    = 1'b0;
              state_d = DONE;
            end else
`endif
            if (byte_idx_q != 4'd11) begin
              byte_idx_d = byte_idx_q + 4'd1;
              nxt        = 1'b1;
            end else if (ent_q == ELAST) begin
`ifdef L3_UART_TX_HDR_EN
              ck_d   = 1'b1;
              byte_d = csum_q;
`else
              state_d = DONE;
`endif
            end else begin
              ent_d   = ent_q + 5'd1;
              state_d = IDLE;
            end
          end
        end
      end
      DONE: begin
        ent_d   = '0;
        state_d = IDLE;
`ifdef L3_UART_TX_HDR_EN
        csum_d  = '0;
`endif
      end
      default: state_d = IDLE;
    endcase

    // pull the next data byte out of the entry shift register
    if (nxt) begin
      byte_d  = shreg_q[7:0];
      shreg_d = {8'h00, shreg_q[95:8]};
`ifdef L3_UART_TX_HDR_EN
      csum_d  = csum_q + shreg_q[7:0];
`endif
    end

    // outputs registered from next-state values
    tx_d = 1'b1;
    if (state_d == SEND) begin
      if (bit_idx_d == 4'd0)      tx_d = 1'b0;
      else if (bit_idx_d == 4'd9) tx_d = 1'b1;
      else tx_d = byte_d[bit_idx_d[2:0] - 3'd1];
    end
    inc_d  = (state_d == CAPT);
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      byte_q     <= '0;
      byte_idx_q <= '0;
      bit_idx_q  <= '0;
      tmr_q      <= '0;
      ent_q      <= '0;
      tx_q       <= 1'b1;
      inc_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef L3_UART_TX_HDR_EN
      hdr_q      <= 1'b0;
      ck_q       <= 1'b0;
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      byte_q     <= byte_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      tmr_q      <= tmr_d;
      ent_q      <= ent_d;
      tx_q       <= tx_d;
      inc_q      <= inc_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
`ifdef L3_UART_TX_HDR_EN
      hdr_q      <= hdr_d;
      ck_q       <= ck_d;
      csum_q     <= csum_d;
`endif
    end
  end

  assign tx          = tx_q;
  assign addr_rd_inc = inc_q;
  assign tx_done     = done_q;
  assign busy        = busy_q;

endmodule

// File: doc/l3_uart_tx.md
Name: l3_uart_tx

Overview:
- Drains pooled feature entries from the layer-3 pooling/RAM block and serializes them to the host over an 8N1 UART line.
- Reads one entry (4 channels x 18-bit signed) whenever the data-available flag is high, then pulses the read-address increment.
- After a full frame of NUM_ENTRIES entries, pulses tx_done so the producer resets its write/read pointers for the next image.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal range 2..65535
- NUM_ENTRIES, 16, entries per frame; legal range 1..31 (5-bit producer address)

Ports:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- rd  in  1  level; producer RAM holds at least one unread entry
- din  in  18 x [3:0]  producer RAM read data; din[c] is channel c, signed
- addr_rd_inc  out  1  one-cycle pulse; advance producer read address
- tx_done  out  1  one-cycle pulse; frame complete, producer clears its pointers
- tx  out  1  UART serial out, idle high
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset, async: tx=1, addr_rd_inc=0, tx_done=0, busy=0, state=IDLE, entry count=0, byte index=0, bit counters=0. Reset mid-byte aborts the byte immediately and tx returns high; no partial state survives.
- FSM states: IDLE, WAIT, CAPT, SEND, DONE.
- IDLE: if rd=1, go to WAIT. Otherwise stay.
- WAIT: one cycle for the registered RAM output to become valid. Go to CAPT.
- CAPT:
  - Latch din into a 96-bit shift register. Each channel is sign-extended to 24 bits. Order is ch0 first; within a channel, LS byte first.
  - Assert addr_rd_inc for exactly this cycle.
  - Go to SEND.
  - The producer's rd/din may change afterward; they are not sampled again until the next IDLE.
- SEND: transmit 12 bytes back-to-back with no idle gap.
  - Each byte is a start bit (0), 8 data bits LSB first, and a stop bit (1). Every bit lasts exactly CLKS_PER_BIT cycles.
  - After the stop bit of byte 11:
    - If entry count = NUM_ENTRIES-1, go to DONE.
    - Otherwise increment entry count and go to IDLE.
- DONE:
  - Assert tx_done for one cycle.
  - Clear entry count.
  - Go to IDLE.
  - tx stays high.
- Latency and throughput:
  - rd rising in IDLE -> addr_rd_inc 2 cycles later.
  - First start bit on tx 3 cycles after rd.
  - Entry period is 3 + 120*CLKS_PER_BIT cycles.
  - tx_done is asserted the cycle after the last stop bit completes.
- rd=0 in IDLE mid-frame: wait indefinitely; the entry count is held. Frame boundaries are tracked only by the count.
- rd must not be sampled in WAIT/CAPT/SEND/DONE. A stale rd high right after addr_rd_inc must not cause a duplicate read.
- Counters: the bit-timer wraps at CLKS_PER_BIT-1 and is sized $clog2(CLKS_PER_BIT). Byte index runs 0..11. Bit index runs 0..9.

Optional Feature:
- L3_UART_TX_HDR_EN
- Defined:
  - Before entry 0 of each frame, send one header byte 0xA5.
  - After the last entry, send one checksum byte: 8-bit modular sum of all data bytes in the frame.
  - tx_done follows the checksum stop bit.
  - Frame length is 12*NUM_ENTRIES+2 bytes.
- Undefined:
  - No header or checksum.
  - Frame length is 12*NUM_ENTRIES bytes.

Test Plan (CLKS_PER_BIT=4, NUM_ENTRIES=2):
- Reset -> tx=1, busy=0, addr_rd_inc=0, tx_done=0. Assert rst_n low mid-byte -> tx=1 within the same cycle, and FSM returns to IDLE.
- rd=1 with din[0]=18'h1FFFF, din[1]=18'h20000, din[2]=18'h00001, din[3]=18'h3FFFF -> tx bytes FF FF 01 00 00 FE 01 00 00 FF FF FF. Each bit is 4 cycles; addr_rd_inc pulses once, 2 cycles after rd.
- rd held high continuously for 2 entries -> exactly 2 addr_rd_inc pulses, 24 bytes, one tx_done pulse 1 cycle after the final stop bit. Entry count is back to 0.
- rd drops to 0 after entry 0 for 500 cycles, then rises -> no tx activity during the gap and no tx_done. Entry 1 then sends and tx_done fires.
- L3_UART_TX_HDR_EN defined, both entries all-zero din -> byte stream A5, 24 x 00, then checksum 00. Entries with din[0]=18'h00001, others 0 -> checksum 02.
- Bit timing check: measure start-bit low period = 4 cycles and stop-bit high period = 4 cycles. Consecutive bytes within an entry show no extra idle cycles.
